// File: rtl/zxjoy_pkg.sv
// rtl/zxjoy_pkg.sv - shared constants and types for the joystick shift-register responder
package zxjoy_pkg;

   localparam int   ZXJOY_NBITS_DEFAULT = 16;
   localparam int   ZXJOY_SYNC_DEFAULT  = 2;
   localparam logic ZXJOY_IDLE          = 1'b1;

   // Frame layout, MSB first on the wire: joy1 occupies the upper byte, joy2 the lower
   localparam int ZXJOY_J1_UP    = 15;
   localparam int ZXJOY_J1_DOWN  = 14;
   localparam int ZXJOY_J1_LEFT  = 13;
   localparam int ZXJOY_J1_RIGHT = 12;
   localparam int ZXJOY_J1_FIRE1 = 11;
   localparam int ZXJOY_J1_FIRE2 = 10;
   localparam int ZXJOY_J1_FIRE3 = 9;
   localparam int ZXJOY_J1_START = 8;
   localparam int ZXJOY_J2_UP    = 7;
   localparam int ZXJOY_J2_DOWN  = 6;
   localparam int ZXJOY_J2_LEFT  = 5;
   localparam int ZXJOY_J2_RIGHT = 4;
   localparam int ZXJOY_J2_FIRE1 = 3;
   localparam int ZXJOY_J2_FIRE2 = 2;
   localparam int ZXJOY_J2_FIRE3 = 1;
   localparam int ZXJOY_J2_START = 0;

   typedef enum logic {
      ST_LOAD  = 1'b0,
      ST_SHIFT = 1'b1
   } zxjoy_state_t;

endpackage

// File: rtl/zxjoy_sync.sv
// rtl/zxjoy_sync.sv - multi-flop synchroniser with one edge-detect flop
// toggle flags any edge; the caller qualifies direction with level.
module zxjoy_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic toggle
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
      end
   end

   assign level  = chain[STAGES-1];
   assign toggle = level ^ prev;

endmodule

// File: rtl/zxjoy_sr_responder.sv
// rtl/zxjoy_sr_responder.sv - 74HC165-style serialiser of a core-side joystick word
// Middleboard drives xjoy_clk/xjoy_load_n asynchronously; both are resynchronised to clk50mhz.
module zxjoy_sr_responder
   import zxjoy_pkg::*;
#(
   parameter int   NBITS       = ZXJOY_NBITS_DEFAULT,
   parameter int   SYNC_STAGES = ZXJOY_SYNC_DEFAULT,
   parameter logic SER_FILL    = ZXJOY_IDLE
) (
   input  logic             clk50mhz,
   input  logic             reset_n,
   input  logic [NBITS-1:0] data_in,
   input  logic             xjoy_clk,
   input  logic             xjoy_load_n,
   output logic             xjoy_data,
   output logic             frame_done,
   output logic             overrun
);

   localparam int             CW       = $clog2(NBITS + 1);
   localparam logic [CW-1:0]  CNT_FULL = CW'(NBITS);
   localparam logic [CW-1:0]  CNT_LAST = CW'(NBITS - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   logic [1:0]       rst_pipe;
   logic             rst_n_int;
   logic             clk_level, clk_toggle, clk_rise;
   logic             load_level, load_toggle, load_rise, load_fall;
   logic             load_now;
   zxjoy_state_t     state;
   logic [NBITS-1:0] shreg;
   logic [CW-1:0]    count;

   // Reset asserts immediately but releases in step with clk50mhz
   always_ff @(posedge clk50mhz or negedge reset_n) begin
      if (!reset_n) rst_pipe <= 2'b00;
      else          rst_pipe <= {rst_pipe[0], 1'b1};
   end
   assign rst_n_int = rst_pipe[1];

   zxjoy_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
      .clk    (clk50mhz),
      .rst_n  (rst_n_int),
      .din    (xjoy_clk),
      .level  (clk_level),
      .toggle (clk_toggle)
   );

   zxjoy_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_load_sync (
      .clk    (clk50mhz),
      .rst_n  (rst_n_int),
      .din    (xjoy_load_n),
      .level  (load_level),
      .toggle (load_toggle)
   );

   assign clk_rise  = clk_level & clk_toggle;
   assign load_rise = load_level & load_toggle;
   assign load_fall = ~load_level & load_toggle;

   // Loading persists from the falling load edge until the rising one; that release cycle may shift
   always_comb begin
      load_now = 1'b0;
      if (state == ST_SHIFT) load_now = load_fall;
      else                   load_now = ~load_rise;
   end

   always_ff @(posedge clk50mhz or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state      <= ST_SHIFT;
         shreg      <= {NBITS{SER_FILL}};
         count      <= '0;
         xjoy_data  <= SER_FILL;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         xjoy_data  <= shreg[NBITS-1];

         case (state)
            ST_LOAD:  if (load_rise) state <= ST_SHIFT;
            ST_SHIFT: if (load_fall) state <= ST_LOAD;
            default:  state <= ST_SHIFT;
         endcase

         if (load_now) begin
            shreg <= data_in;
            count <= '0;
         end else if (clk_rise) begin
            shreg <= {shreg[NBITS-2:0], SER_FILL};
            if (count == CNT_FULL) begin
               overrun <= 1'b1;
            end else begin
               count      <= count + CNT_ONE;
               frame_done <= (count == CNT_LAST);
            end
         end
      end
   end

endmodule

// File: tb/tb_zxjoy_sr_responder.sv
// tb/tb_zxjoy_sr_responder.sv - directed vector bench for the joystick shift-register responder
module tb_zxjoy_sr_responder;

   logic        clk50mhz = 1'b0;
   logic        reset_n;
   logic [15:0] data_in;
   logic        xjoy_clk;
   logic        xjoy_load_n;
   logic        xjoy_data;
   logic        frame_done;
   logic        overrun;

   int checks   = 0;
   int failures = 0;
   int fd_cnt   = 0;
   int ov_cnt   = 0;

   typedef struct {
      logic [15:0] din;
      int          toggles;
      int          chg_after;
      logic [15:0] chg_val;
      logic [15:0] exp_word;
   } vec_t;

   vec_t vecs [7];

   zxjoy_sr_responder #(.NBITS(16), .SYNC_STAGES(2), .SER_FILL(1'b1)) dut (
      .clk50mhz    (clk50mhz),
      .reset_n     (reset_n),
      .data_in     (data_in),
      .xjoy_clk    (xjoy_clk),
      .xjoy_load_n (xjoy_load_n),
      .xjoy_data   (xjoy_data),
      .frame_done  (frame_done),
      .overrun     (overrun)
   );

   always #10 clk50mhz = ~clk50mhz;

   always @(negedge clk50mhz) begin
      if (frame_done === 1'b1) fd_cnt++;
      if (overrun === 1'b1)    ov_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk50mhz);
   endtask

   task automatic pulse_edge();
      xjoy_clk = 1'b1;
      tick(10);
      xjoy_clk = 1'b0;
      tick(10);
   endtask

   task automatic do_load(input logic [15:0] din, input int toggles, input logic exp_msb);
      data_in     = din;
      xjoy_load_n = 1'b0;
      tick(8);
      repeat (toggles) begin
         xjoy_clk = 1'b1;
         tick(5);
         xjoy_clk = 1'b0;
         tick(5);
      end
      tick(4);
      chk("load_hold", xjoy_data, exp_msb);
      xjoy_load_n = 1'b1;
      tick(10);
   endtask

   task automatic shift_frame(input int chg_after, input logic [15:0] chg_val,
                              output logic [15:0] got, output int fd_before, output int fd_after);
      int snap;
      snap    = fd_cnt;
      got[15] = xjoy_data;
      for (int i = 1; i < 16; i++) begin
         pulse_edge();
         if (i == chg_after) data_in = chg_val;
         got[15-i] = xjoy_data;
      end
      fd_before = fd_cnt - snap;
      pulse_edge();
      fd_after = fd_cnt - snap;
   endtask

   initial begin
      logic [15:0] got;
      int          fb, fa, ov_snap, fd_snap;

      vecs[0] = '{16'hA5C3, 0, -1, 16'h0000, 16'hA5C3};
      vecs[1] = '{16'h0001, 5, -1, 16'h0000, 16'h0001};
      vecs[2] = '{16'hFFFF, 0,  4, 16'h0000, 16'hFFFF};
      vecs[3] = '{16'h0000, 0, -1, 16'h0000, 16'h0000};
      vecs[4] = '{16'h8001, 0, -1, 16'h0000, 16'h8001};
      vecs[5] = '{16'h1234, 0,  8, 16'hFFFF, 16'h1234};
      vecs[6] = '{16'h5A3C, 2, -1, 16'h0000, 16'h5A3C};

      reset_n     = 1'b0;
      xjoy_clk    = 1'b0;
      xjoy_load_n = 1'b1;
      data_in     = 16'hA5C3;
      tick(3);
      chk("reset_data", xjoy_data, 1'b1);
      chk("reset_frame_done", frame_done, 1'b0);
      chk("reset_overrun", overrun, 1'b0);
      reset_n = 1'b1;
      tick(5);
      chk("post_reset_data", xjoy_data, 1'b1);

      for (int v = 0; v < 7; v++) begin
         ov_snap = ov_cnt;
         do_load(vecs[v].din, vecs[v].toggles, vecs[v].exp_word[15]);
         shift_frame(vecs[v].chg_after, vecs[v].chg_val, got, fb, fa);
         chk($sformatf("frame%0d_word", v), got, vecs[v].exp_word);
         chk($sformatf("frame%0d_fd_early", v), fb, 0);
         chk($sformatf("frame%0d_fd_count", v), fa, 1);
         chk($sformatf("frame%0d_no_overrun", v), ov_cnt - ov_snap, 0);
      end

      // Pin-to-data latency on a shift edge
      do_load(16'hA5C3, 0, 1'b1);
      chk("lat_before", xjoy_data, 1'b1);
      xjoy_clk = 1'b1;
      tick(3);
      chk("lat_t3", xjoy_data, 1'b1);
      tick(1);
      chk("lat_t4", xjoy_data, 1'b0);
      tick(6);
      xjoy_clk = 1'b0;
      tick(10);

      // Edges past the end of a frame
      do_load(16'hA5C3, 0, 1'b1);
      shift_frame(-1, 16'h0000, got, fb, fa);
      chk("ovr_frame_word", got, 16'hA5C3);
      ov_snap = ov_cnt;
      fd_snap = fd_cnt;
      for (int k = 0; k < 3; k++) begin
         pulse_edge();
         chk($sformatf("ovr_data%0d", k), xjoy_data, 1'b1);
      end
      chk("ovr_count", ov_cnt - ov_snap, 3);
      chk("ovr_no_fd", fd_cnt - fd_snap, 0);
      do_load(16'h7FFF, 0, 1'b0);
      chk("ovr_reload", xjoy_data, 1'b0);

      // Reset mid-frame
      do_load(16'hA5C3, 0, 1'b1);
      for (int k = 0; k < 6; k++) pulse_edge();
      chk("mid_pre_reset_bit", xjoy_data, 1'b0);
      fd_snap = fd_cnt;
      reset_n = 1'b0;
      #1;
      chk("mid_reset_data", xjoy_data, 1'b1);
      tick(5);
      reset_n = 1'b1;
      tick(10);
      chk("mid_after_release", xjoy_data, 1'b1);
      chk("mid_no_fd", fd_cnt - fd_snap, 0);
      do_load(16'hA5C3, 0, 1'b1);
      shift_frame(-1, 16'h0000, got, fb, fa);
      chk("mid_reframe_word", got, 16'hA5C3);
      chk("mid_reframe_fd", fa, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
